neuron_mac: RTL

- Sequential multiply-accumulate neuron, the parametrised successor of the single-tap float neuron.
- Consumes a stream of (data, tap) float pairs framed by first/last flags and accumulates their products onto a bias sampled at frame start.
- Emits one rounded float result per frame over a valid/ready handshake, with an optional ReLU.
- Float format generalised to EXP_W/MAN_W; adds zero handling, overflow saturation and underflow flush.

---
 rtl/neuron_mac.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/neuron_mac.sv
// Sequential multiply-accumulate neuron on a parametrised {sgn, exp, man} float format.
// Beats flow through three registers: operand capture, multiply, accumulate.
// The frame result is then held on a valid/ready output until it is taken.
module neuron_mac #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned CNT_W = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   relu_en,
    input  logic [EXP_W+MAN_W:0]   bias,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [EXP_W+MAN_W:0]   data,
    input  logic [EXP_W+MAN_W:0]   tap,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out,
    output logic [CNT_W-1:0]       tap_count,
    output logic                   proto_err
);

    localparam int FW   = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX = (1 << EXP_W) - 2;
    // Aligned magnitude: hidden bit, mantissa, MAN_W guard/sticky bits below.
    localparam int AW   = 2 * MAN_W + 1;
    localparam logic [EXP_W-1:0] EXP_SAT = {{(EXP_W - 1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {StIdle, StAcc, StDrain, StHold} state_e;

    // Apply saturation on overflow and flush-to-zero on underflow.
    function automatic logic [FW-1:0] pack(input logic s, input int e, input logic [MAN_W-1:0] m);
        if (e > EMAX) return {s, EXP_SAT, {MAN_W{1'b1}}};
        if (e <= 0) return '0;
        return {s, e[EXP_W-1:0], m};
    endfunction

    // Float multiply, round half-up; a zero-exponent operand yields a zero product.
    function automatic logic [FW-1:0] fmul(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic               s;
        logic [EXP_W-1:0]   ea, eb;
        logic [2*MAN_W+1:0] ma, mb;
        logic [MAN_W+2:0]   top;
        logic [MAN_W-1:0]   f;
        logic               rb;
        logic [MAN_W:0]     fr;
        int                 e;
        s  = a[FW-1] ^ b[FW-1];
        ea = a[FW-2 -: EXP_W];
        eb = b[FW-2 -: EXP_W];
        if (ea == '0 || eb == '0) return {s, {(FW - 1){1'b0}}};
        ma  = {{(MAN_W + 1){1'b0}}, 1'b1, a[MAN_W-1:0]};
        mb  = {{(MAN_W + 1){1'b0}}, 1'b1, b[MAN_W-1:0]};
        // Keep only the hidden-bit region plus the round bit of the full product.
        top = (MAN_W + 3)'((ma * mb) >> (MAN_W - 1));
        e   = int'(ea) + int'(eb) - BIAS;
        if (top[MAN_W+2]) begin
            f  = top[MAN_W+1:2];
            rb = top[1];
            e  = e + 1;
        end else begin
            f  = top[MAN_W:1];
            rb = top[0];
        end
        fr = {1'b0, f} + {{MAN_W{1'b0}}, rb};
        if (fr[MAN_W]) e = e + 1;
        return pack(s, e, fr[MAN_W-1:0]);
    endfunction

    // Float add: align, two's-complement sum, leading-one renormalise, round to nearest even.
    function automatic logic [FW-1:0] fadd(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic [AW-1:0]          ma, mb, mbig, msml, mask;
        logic                   sbig, ssml, st, sg, rnd;
        logic signed [AW+1:0]   vb, vs, sum;
        logic [AW+1:0]          mag, norm;
        logic [MAN_W:0]         fr;
        int                     ea, eb, eg, d, p, e;
        ea = int'(a[FW-2 -: EXP_W]);
        eb = int'(b[FW-2 -: EXP_W]);
        ma = (ea == 0) ? '0 : {1'b1, a[MAN_W-1:0], {MAN_W{1'b0}}};
        mb = (eb == 0) ? '0 : {1'b1, b[MAN_W-1:0], {MAN_W{1'b0}}};
        if (ea >= eb) begin
            mbig = ma; sbig = a[FW-1]; msml = mb; ssml = b[FW-1]; eg = ea; d = ea - eb;
        end else begin
            mbig = mb; sbig = b[FW-1]; msml = ma; ssml = a[FW-1]; eg = eb; d = eb - ea;
        end
        if (d >= AW) begin
            st   = |msml;
            msml = '0;
        end else begin
            mask = ~({AW{1'b1}} << d);
            st   = |(msml & mask);
            msml = msml >> d;
        end
        msml[0] = msml[0] | st;
        vb = $signed({2'b00, mbig});
        vs = $signed({2'b00, msml});
        if (sbig) vb = -vb;
        if (ssml) vs = -vs;
        sum = vb + vs;
        sg  = sum[AW+1];
        mag = sg ? $unsigned(-sum) : $unsigned(sum);
        p = 0;
        for (int i = 0; i < AW + 2; i++) begin
            if (mag[i]) p = i;
        end
        norm = mag << (AW + 1 - p);
        // No leading one means exact cancellation (or two zeros): result is +0.
        if (!norm[AW+1]) return '0;
        e   = eg + p - (AW - 1);
        rnd = norm[MAN_W+1] & ((|norm[MAN_W:0]) | norm[MAN_W+2]);
        fr  = {1'b0, norm[AW -: MAN_W]} + {{MAN_W{1'b0}}, rnd};
        if (fr[MAN_W]) e = e + 1;
        return pack(sg, e, fr[MAN_W-1:0]);
    endfunction

    state_e           state_q;
    logic             accept, take;
    logic             op_v_q, op_first_q, op_last_q;
    logic [FW-1:0]    a_q, b_q, bias_q, prod_q, acc_q, out_q;
    logic             prod_v_q, prod_first_q, prod_last_q, done_q, relu_q;
    logic [CNT_W-1:0] count_q, tap_count_q;
    logic             out_valid_q, proto_err_q;

    assign in_ready  = (state_q == StIdle) || (state_q == StAcc);
    assign accept    = in_valid & in_ready;
    // Beats outside a frame are dropped; they never enter the pipeline.
    assign take      = accept & (in_first | (state_q == StAcc));
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign tap_count = tap_count_q;
    assign proto_err = proto_err_q;

    // Datapath: operand capture, multiply, accumulate and beat counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_v_q       <= 1'b0;
            op_first_q   <= 1'b0;
            op_last_q    <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            bias_q       <= '0;
            relu_q       <= 1'b0;
            prod_v_q     <= 1'b0;
            prod_first_q <= 1'b0;
            prod_last_q  <= 1'b0;
            prod_q       <= '0;
            acc_q        <= '0;
            done_q       <= 1'b0;
            count_q      <= '0;
        end else begin
            op_v_q       <= take;
            op_first_q   <= in_first;
            op_last_q    <= in_last;
            if (take) begin
                a_q <= data;
                b_q <= tap;
                if (in_first) begin
                    bias_q  <= bias;
                    relu_q  <= relu_en;
                    count_q <= CNT_W'(1);
                end else if (count_q != '1) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end
            prod_v_q     <= op_v_q;
            prod_first_q <= op_first_q;
            prod_last_q  <= op_last_q;
            if (op_v_q) prod_q <= fmul(a_q, b_q);
            if (prod_v_q) acc_q <= fadd(prod_first_q ? bias_q : acc_q, prod_q);
            done_q       <= prod_v_q & prod_last_q;
        end
    end

    // Frame control FSM with registered result, count and error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            tap_count_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (!in_first)    proto_err_q <= 1'b1;
                        else if (in_last) state_q     <= StDrain;
                        else              state_q     <= StAcc;
                    end
                end
                StAcc: begin
                    if (accept) begin
                        if (in_first) proto_err_q <= 1'b1;
                        if (in_last)  state_q     <= StDrain;
                    end
                end
                StDrain: begin
                    if (done_q) begin
                        state_q     <= StHold;
                        out_q       <= (relu_q && acc_q[FW-1]) ? '0 : acc_q;
                        out_valid_q <= 1'b1;
                        tap_count_q <= count_q;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
